// File: rtl/qam_demapper.sv
// Hard-decision BPSK/QPSK/16QAM demapper: two-stage valid/ready pipeline with
// per-frame latching of mode and 16QAM threshold.
module qam_demapper #(
    parameter int W         = 16,
    parameter int FRAME_LEN = 64,
    parameter int CW        = $clog2(FRAME_LEN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] I_in,
    input  logic signed [W-1:0] Q_in,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          mode,
    input  logic [W-2:0]        thr,
    output logic [3:0]          bits,
    output logic [2:0]          nbits,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic [CW-1:0]       sym_idx,
    output logic                mode_err
);

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'd0,
        MODE_QPSK  = 2'd1,
        MODE_16QAM = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_t;

    mode_t         mode_q, mode_eff, mode_s1;
    logic [W-2:0]  thr_q, thr_eff, thr_s1;
    logic [CW-1:0] cnt, idx_s1;
    logic          s1_valid, sign_i_s1, sign_q_s1;
    logic [W-2:0]  abs_i, abs_q, abs_i_s1, abs_q_s1;
    logic          s2_adv, accept, frame_start;
    logic [3:0]    dec_bits;
    logic [2:0]    dec_nbits;

    // Magnitude on W-1 bits; the most negative code saturates to all-ones.
    function automatic logic [W-2:0] sat_abs(input logic [W-1:0] x);
        logic [W-1:0] neg;
        neg = ~x + 1'b1;
        if (!x[W-1])
            return x[W-2:0];
        else if (x[W-2:0] == '0)
            return '1;
        else
            return neg[W-2:0];
    endfunction

    assign abs_i       = sat_abs(I_in);
    assign abs_q       = sat_abs(Q_in);
    assign s2_adv      = ~out_valid | out_ready;
    assign in_ready    = (~s1_valid | s2_adv) & ~rst;
    assign accept      = in_valid & in_ready;
    assign frame_start = (cnt == '0);

    // The first symbol of a frame is decoded with the values it latches.
    assign mode_eff = frame_start ? mode_t'(mode) : mode_q;
    assign thr_eff  = frame_start ? thr : thr_q;

    always_comb begin
        dec_bits  = '0;
        dec_nbits = 3'd2;
        case (mode_s1)
            MODE_BPSK: begin
                dec_bits  = {3'b000, ~sign_i_s1};
                dec_nbits = 3'd1;
            end
            MODE_16QAM: begin
                dec_bits  = {abs_q_s1 < thr_s1, abs_i_s1 < thr_s1, ~sign_q_s1, ~sign_i_s1};
                dec_nbits = 3'd4;
            end
            default: begin
                dec_bits  = {2'b00, ~sign_q_s1, ~sign_i_s1};
                dec_nbits = 3'd2;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            sign_i_s1 <= 1'b0;
            sign_q_s1 <= 1'b0;
            abs_i_s1  <= '0;
            abs_q_s1  <= '0;
            mode_s1   <= MODE_QPSK;
            thr_s1    <= '0;
            idx_s1    <= '0;
            cnt       <= '0;
            mode_q    <= MODE_QPSK;
            thr_q     <= '0;
            mode_err  <= 1'b0;
            out_valid <= 1'b0;
            bits      <= '0;
            nbits     <= '0;
            out_last  <= 1'b0;
            sym_idx   <= '0;
        end else begin
            if (accept) begin
                s1_valid  <= 1'b1;
                sign_i_s1 <= I_in[W-1];
                sign_q_s1 <= Q_in[W-1];
                abs_i_s1  <= abs_i;
                abs_q_s1  <= abs_q;
                mode_s1   <= mode_eff;
                thr_s1    <= thr_eff;
                idx_s1    <= cnt;
                cnt       <= (cnt == CW'(FRAME_LEN - 1)) ? '0 : cnt + 1'b1;
                if (frame_start) begin
                    mode_q <= mode_eff;
                    thr_q  <= thr_eff;
                    if (mode_eff == MODE_RSVD)
                        mode_err <= 1'b1;
                end
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    bits     <= dec_bits;
                    nbits    <= dec_nbits;
                    out_last <= (idx_s1 == CW'(FRAME_LEN - 1));
                    sym_idx  <= idx_s1;
                end
            end
        end
    end

endmodule
